// File: rtl/regs_sb_pkg.sv
// Shared types and helpers for the register file with integrated busy-bit scoreboard.
// Optional feature macro used by this slice: REGS_SB_FWD_EN (same-cycle writeback bypass).
package regs_sb_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    // Widest busy vector the popcount helper accepts; NREGS must not exceed it.
    localparam int POP_MAX   = 1024;

    typedef logic [AW_DEF-1:0] reg_addr_t;

    // x0 is hardwired to zero and never tracked by the scoreboard.
    localparam reg_addr_t REG_ZERO = '0;

    // Number of set bits; callers zero-extend narrower vectors into POP_MAX bits.
    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            n += {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/regs_sb_if.sv
// Decode/writeback bus of the register file. The slave modport is the register file,
// the master modport is the pipeline (decode + writeback stages).
interface regs_sb_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr_i;
    logic [NRD*XLEN-1:0] rd_data_o;
    logic [NRD-1:0]      rd_busy_o;
    logic [NRD-1:0]      rd_used_i;
    logic                iss_valid_i;
    logic                iss_wen_i;
    logic [AW-1:0]       iss_waddr_i;
    logic                stall_o;
    logic                wb_wen_i;
    logic [AW-1:0]       wb_waddr_i;
    logic [XLEN-1:0]     wb_wdata_i;
    logic                flush_i;
    logic [AW:0]         busy_cnt_o;

    modport slave (
        input  rd_addr_i, rd_used_i, iss_valid_i, iss_wen_i, iss_waddr_i,
               wb_wen_i, wb_waddr_i, wb_wdata_i, flush_i,
        output rd_data_o, rd_busy_o, stall_o, busy_cnt_o
    );

    modport master (
        output rd_addr_i, rd_used_i, iss_valid_i, iss_wen_i, iss_waddr_i,
               wb_wen_i, wb_waddr_i, wb_wdata_i, flush_i,
        input  rd_data_o, rd_busy_o, stall_o, busy_cnt_o
    );
endinterface

// File: rtl/regs_sb_scoreboard.sv
// Busy-bit vector with flush > set > clear priority, plus a registered popcount of the vector.
module regs_scoreboard
    import regs_sb_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             set_en_i,
    input  logic [AW-1:0]    set_addr_i,
    input  logic             clr_en_i,
    input  logic [AW-1:0]    clr_addr_i,
    input  logic             flush_i,
    output logic [NREGS-1:0] busy_o,
    output logic [AW:0]      busy_cnt_o
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_next;
    logic [AW:0]      r_busy_cnt;

    // Next busy state: flush wipes everything; otherwise clear first so a same-edge set wins.
    always_comb begin
        w_busy_next = r_busy;
        if (flush_i) begin
            w_busy_next = '0;
        end else begin
            if (clr_en_i) w_busy_next[clr_addr_i] = 1'b0;
            if (set_en_i) w_busy_next[set_addr_i] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // Busy bits and their count are updated together so the count always matches the vector.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_next;
            r_busy_cnt <= (AW+1)'(popcount(POP_MAX'(w_busy_next)));
        end
    end

    assign busy_o     = r_busy;
    assign busy_cnt_o = r_busy_cnt;

endmodule

// File: rtl/regs_sb.sv
// Register file (x0 hardwired to zero) with NRD combinational read ports and an
// integrated busy-bit scoreboard that produces the decode stall.
// Define REGS_SB_FWD_EN to bypass same-cycle writeback data/busy onto the read ports.
module regs_sb
    import regs_sb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF
) (
    input  logic     clk_i,
    input  logic     rst_n_i,
    regs_sb_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic             w_wb_we;
    logic [NREGS-1:0] w_busy;
    logic [NREGS-1:0] w_busy_eff;
    logic [AW:0]      w_busy_cnt;
    logic [AW-1:0]    w_rd_addr [NRD];
    logic [XLEN-1:0]  w_rd_data [NRD];
    logic             w_rd_busy [NRD];
    logic [NRD-1:0]   w_raw;
    logic             w_waw;
    logic             w_stall;
    logic             w_set_en;

    assign w_wb_we = bus.wb_wen_i && (bus.wb_waddr_i != '0);

    // Architectural register array; x0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wb_we) begin
            r_regs[bus.wb_waddr_i] <= bus.wb_wdata_i;
        end
    end

`ifdef REGS_SB_FWD_EN
    // The register retiring this cycle is treated as already free.
    assign w_busy_eff = w_busy & ~(w_wb_we ? (NREGS'(1) << bus.wb_waddr_i) : '0);
`else
    assign w_busy_eff = w_busy;
`endif

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        assign w_rd_addr[gi] = bus.rd_addr_i[gi*AW +: AW];
`ifdef REGS_SB_FWD_EN
        assign w_rd_data[gi] = (w_rd_addr[gi] == '0) ? '0 :
                               (w_wb_we && bus.wb_waddr_i == w_rd_addr[gi]) ? bus.wb_wdata_i :
                               r_regs[w_rd_addr[gi]];
`else
        assign w_rd_data[gi] = (w_rd_addr[gi] == '0) ? '0 : r_regs[w_rd_addr[gi]];
`endif
        assign w_rd_busy[gi] = w_busy_eff[w_rd_addr[gi]];
        assign w_raw[gi]     = bus.rd_used_i[gi] && w_rd_busy[gi];
    end

    // Pack per-port read results onto the bus.
    always_comb begin
        bus.rd_data_o = '0;
        bus.rd_busy_o = '0;
        for (int k = 0; k < NRD; k++) begin
            bus.rd_data_o[k*XLEN +: XLEN] = w_rd_data[k];
            bus.rd_busy_o[k]              = w_rd_busy[k];
        end
    end

    assign w_waw    = bus.iss_wen_i && (bus.iss_waddr_i != '0) && w_busy_eff[bus.iss_waddr_i];
    assign w_stall  = bus.iss_valid_i && ((|w_raw) || w_waw);
    assign w_set_en = bus.iss_valid_i && !w_stall && !bus.flush_i &&
                      bus.iss_wen_i && (bus.iss_waddr_i != '0);

    regs_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .set_en_i   (w_set_en),
        .set_addr_i (bus.iss_waddr_i),
        .clr_en_i   (w_wb_we),
        .clr_addr_i (bus.wb_waddr_i),
        .flush_i    (bus.flush_i),
        .busy_o     (w_busy),
        .busy_cnt_o (w_busy_cnt)
    );

    assign bus.stall_o    = w_stall;
    assign bus.busy_cnt_o = w_busy_cnt;

endmodule

// File: tb/tb_regs_sb.sv
// Directed bench for regs_sb: expectations are queued as stimulus is driven and popped on compare.
module tb_regs_sb;
    import regs_sb_pkg::*;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;

    logic clk;
    logic rst_n;

    regs_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    regs_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    task automatic push_exp(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h expected none", obs);
        end else begin
            e = exp_q.pop_front();
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int port, input logic [4:0] addr, input logic used);
        bus.rd_addr_i[port*5 +: 5] = addr;
        bus.rd_used_i[port]        = used;
    endtask

    task automatic issue(input logic valid, input logic wen, input logic [4:0] addr);
        bus.iss_valid_i = valid;
        bus.iss_wen_i   = wen;
        bus.iss_waddr_i = addr;
    endtask

    task automatic wb(input logic wen, input logic [4:0] addr, input logic [63:0] data);
        bus.wb_wen_i   = wen;
        bus.wb_waddr_i = addr;
        bus.wb_wdata_i = data;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.rd_addr_i = '0;
        bus.rd_used_i = '0;
        issue(1'b0, 1'b0, 5'd0);
        wb(1'b0, 5'd0, 64'd0);
        bus.flush_i = 1'b0;

        // Reset state: read x5 on both ports with a consuming issue.
        set_rd(0, 5'd5, 1'b1);
        set_rd(1, 5'd5, 1'b1);
        issue(1'b1, 1'b0, 5'd0);
        push_exp("rst_data0", 64'd0);
        push_exp("rst_data1", 64'd0);
        push_exp("rst_busy", 64'd0);
        push_exp("rst_cnt", 64'd0);
        push_exp("rst_stall", 64'd0);
        #2;
        check(bus.rd_data_o[63:0]);
        check(bus.rd_data_o[127:64]);
        check(64'(bus.rd_busy_o));
        check(64'(bus.busy_cnt_o));
        check(64'(bus.stall_o));
        issue(1'b0, 1'b0, 5'd0);
        bus.rd_used_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // RAW on x5 and its release by writeback.
        issue(1'b1, 1'b1, 5'd5);
        push_exp("iss5_stall", 64'd0);
        #1;
        check(64'(bus.stall_o));
        tick();
        issue(1'b1, 1'b0, 5'd0);
        set_rd(0, 5'd5, 1'b1);
        push_exp("iss5_cnt", 64'd1);
        push_exp("raw5_busy", 64'd3);
        push_exp("raw5_stall", 64'd1);
        check(64'(bus.busy_cnt_o));
        #1;
        check(64'(bus.rd_busy_o));
        check(64'(bus.stall_o));
        wb(1'b1, 5'd5, 64'hDEAD_BEEF);
`ifdef REGS_SB_FWD_EN
        push_exp("wb5_fwd_data", 64'hDEAD_BEEF);
        push_exp("wb5_fwd_stall", 64'd0);
`else
        push_exp("wb5_nofwd_data", 64'd0);
        push_exp("wb5_nofwd_stall", 64'd1);
`endif
        #1;
        check(bus.rd_data_o[63:0]);
        check(64'(bus.stall_o));
        tick();
        wb(1'b0, 5'd0, 64'd0);
        push_exp("post_wb5_data", 64'hDEAD_BEEF);
        push_exp("post_wb5_stall", 64'd0);
        push_exp("post_wb5_cnt", 64'd0);
        #1;
        check(bus.rd_data_o[63:0]);
        check(64'(bus.stall_o));
        check(64'(bus.busy_cnt_o));
        issue(1'b0, 1'b0, 5'd0);
        bus.rd_used_i = '0;

        // Same edge writeback and issue of x7: the new producer keeps the busy bit.
        wb(1'b1, 5'd7, 64'h77);
        issue(1'b1, 1'b1, 5'd7);
        push_exp("same7_stall", 64'd0);
        #1;
        check(64'(bus.stall_o));
        tick();
        wb(1'b0, 5'd0, 64'd0);
        issue(1'b0, 1'b0, 5'd0);
        set_rd(0, 5'd7, 1'b0);
        push_exp("same7_busy", 64'd1);
        push_exp("same7_data", 64'h77);
        push_exp("same7_cnt", 64'd1);
        #1;
        check(64'(bus.rd_busy_o[0]));
        check(bus.rd_data_o[63:0]);
        check(64'(bus.busy_cnt_o));
        wb(1'b1, 5'd7, 64'h78);
        tick();
        wb(1'b0, 5'd0, 64'd0);
        push_exp("wb7_cnt", 64'd0);
        push_exp("wb7_data", 64'h78);
        check(64'(bus.busy_cnt_o));
        check(bus.rd_data_o[63:0]);

        // Three producers, then a flush that also suppresses a concurrent issue.
        issue(1'b1, 1'b1, 5'd3);
        tick();
        issue(1'b1, 1'b1, 5'd4);
        tick();
        issue(1'b1, 1'b1, 5'd6);
        tick();
        issue(1'b0, 1'b0, 5'd0);
        push_exp("three_cnt", 64'd3);
        check(64'(bus.busy_cnt_o));
        bus.flush_i = 1'b1;
        issue(1'b1, 1'b1, 5'd9);
        tick();
        bus.flush_i = 1'b0;
        issue(1'b0, 1'b0, 5'd0);
        set_rd(0, 5'd9, 1'b0);
        set_rd(1, 5'd3, 1'b0);
        push_exp("flush_cnt", 64'd0);
        push_exp("flush_busy", 64'd0);
        #1;
        check(64'(bus.busy_cnt_o));
        check(64'(bus.rd_busy_o));

        // x0 ignores writes and destinations.
        wb(1'b1, REG_ZERO, 64'hFFFF);
        issue(1'b1, 1'b1, REG_ZERO);
        set_rd(0, REG_ZERO, 1'b1);
        push_exp("x0_stall", 64'd0);
        push_exp("x0_busy", 64'd0);
        #1;
        check(64'(bus.stall_o));
        check(64'(bus.rd_busy_o[0]));
        tick();
        wb(1'b0, 5'd0, 64'd0);
        issue(1'b0, 1'b0, 5'd0);
        push_exp("x0_data", 64'd0);
        push_exp("x0_cnt", 64'd0);
        #1;
        check(bus.rd_data_o[63:0]);
        check(64'(bus.busy_cnt_o));
        bus.rd_used_i = '0;

        // WAW on busy x8.
        issue(1'b1, 1'b1, 5'd8);
        tick();
        push_exp("waw8_stall", 64'd1);
        push_exp("waw8_cnt", 64'd1);
        #1;
        check(64'(bus.stall_o));
        check(64'(bus.busy_cnt_o));

        // Asynchronous reset in the middle of a stall on x2.
        issue(1'b1, 1'b1, 5'd2);
        tick();
        issue(1'b1, 1'b0, 5'd0);
        set_rd(0, 5'd2, 1'b1);
        set_rd(1, 5'd5, 1'b0);
        push_exp("pre_rst_cnt", 64'd2);
        push_exp("pre_rst_stall", 64'd1);
        check(64'(bus.busy_cnt_o));
        #1;
        check(64'(bus.stall_o));
        #1;
        rst_n = 1'b0;
        push_exp("async_rst_cnt", 64'd0);
        push_exp("async_rst_stall", 64'd0);
        push_exp("async_rst_busy", 64'd0);
        push_exp("async_rst_data5", 64'd0);
        #1;
        check(64'(bus.busy_cnt_o));
        check(64'(bus.stall_o));
        check(64'(bus.rd_busy_o));
        check(bus.rd_data_o[127:64]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
